// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: parity-mode codes,
// the receiver state encoding and the parity check rule.
package uart_rx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit index counter width; covers up to 9 data bits and 2 stop bits.
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic parityBad(input logic payloadXor, input logic parityBit,
                                     input int mode);
    logic total;
    total = payloadXor ^ parityBit;
    case (mode)
      PAR_ODD:  return !total;
      PAR_EVEN: return total;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, received payload and frame status out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output data,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_param_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset
// to RESET_VAL so the synchronized output starts at a known idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling with start-glitch rejection,
// parity and framing checks, and one data_valid pulse per received frame.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input logic             clk,
  input logic             rst,
  uart_rx_param_if.master rxIf
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0]    HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CPB - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  logic rxS;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parErr_q, parErr_d;
  logic                 frmErr_q, frmErr_d;
  logic                 lastStop_q, lastStop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 parOut_q, parOut_d;
  logic                 frmOut_q, frmOut_d;

  // Idle-high reset value keeps the line from looking like a start bit.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) uRxSync (
    .clk(clk),
    .rst(rst),
    .d_i(rxIf.rx),
    .q_o(rxS)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parErr_q   <= 1'b0;
      frmErr_q   <= 1'b0;
      lastStop_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      parOut_q   <= 1'b0;
      frmOut_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parErr_q   <= parErr_d;
      frmErr_q   <= frmErr_d;
      lastStop_q <= lastStop_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      parOut_q   <= parOut_d;
      frmOut_q   <= frmOut_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    parErr_d   = parErr_q;
    frmErr_d   = frmErr_q;
    lastStop_d = lastStop_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    parOut_d   = 1'b0;
    frmOut_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxS) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rxS) begin
            state_d  = S_DATA;
            cnt_d    = '0;
            idx_d    = '0;
            parErr_d = 1'b0;
            frmErr_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Counter origin is mid-start, so a full bit period lands mid-bit.
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {rxS, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          parErr_d = parityBad(^shift_q, rxS, PARITY);
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Delivery happens one cycle after the last stop sample.
      S_STOP: begin
        if (lastStop_q) begin
          data_d     = shift_q;
          valid_d    = 1'b1;
          parOut_d   = parErr_q;
          frmOut_d   = frmErr_q;
          lastStop_d = 1'b0;
          state_d    = S_IDLE;
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rxS) begin
            frmErr_d = 1'b1;
          end
          if (idx_q == STOP_LAST) begin
            lastStop_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rxIf.data       = data_q;
  assign rxIf.data_valid = valid_q;
  assign rxIf.parity_err = parOut_q;
  assign rxIf.frame_err  = frmOut_q;
  assign rxIf.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receiver configurations on one clock, driven
// frame by frame and checked against a frame-level model of payload, flags and latency.
module tb_uart_rx_param;
  import uart_rx_param_pkg::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } rxItem_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rxLine;
  int         cyc = 0;
  int         checkCnt = 0;
  int         passCnt = 0;
  int         failCnt = 0;
  int         flagViol = 0;
  int         busyCycA = 0;
  rxItem_t    qA[$];
  rxItem_t    qB[$];
  rxItem_t    qC[$];

  uart_rx_param_if #(.DATA_BITS(8)) ifA ();
  uart_rx_param_if #(.DATA_BITS(8)) ifB ();
  uart_rx_param_if #(.DATA_BITS(7)) ifC ();

  assign ifA.rx = rxLine[0];
  assign ifB.rx = rxLine[1];
  assign ifC.rx = rxLine[2];

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)
  ) dutA (.clk(clk), .rst(rst), .rxIf(ifA));

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(2)
  ) dutB (.clk(clk), .rst(rst), .rxIf(ifB));

  uart_rx_param #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(1)
  ) dutC (.clk(clk), .rst(rst), .rxIf(ifC));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rxItem_t mkItem(input logic [8:0] d, input logic pe, input logic fe,
                                     input int c);
    rxItem_t it;
    it.data = d;
    it.pe   = pe;
    it.fe   = fe;
    it.cyc  = c;
    return it;
  endfunction

  // Capture every delivered frame and any error flag raised outside data_valid.
  always @(negedge clk) begin
    if (ifA.data_valid === 1'b1) qA.push_back(mkItem({1'b0, ifA.data}, ifA.parity_err, ifA.frame_err, cyc));
    if (ifB.data_valid === 1'b1) qB.push_back(mkItem({1'b0, ifB.data}, ifB.parity_err, ifB.frame_err, cyc));
    if (ifC.data_valid === 1'b1) qC.push_back(mkItem({2'b0, ifC.data}, ifC.parity_err, ifC.frame_err, cyc));
    if ((ifA.data_valid !== 1'b1 && (ifA.parity_err !== 1'b0 || ifA.frame_err !== 1'b0)) ||
        (ifB.data_valid !== 1'b1 && (ifB.parity_err !== 1'b0 || ifB.frame_err !== 1'b0)) ||
        (ifC.data_valid !== 1'b1 && (ifC.parity_err !== 1'b0 || ifC.frame_err !== 1'b0)))
      flagViol++;
    if (ifA.busy === 1'b1) busyCycA++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int laneBits(input int lane);
    return (lane == 2) ? 7 : 8;
  endfunction

  function automatic int lanePar(input int lane);
    case (lane)
      1:       return PAR_EVEN;
      2:       return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic int laneStop(input int lane);
    return (lane == 1) ? 2 : 1;
  endfunction

  function automatic int countOnes(input logic [8:0] p, input int nBits);
    int ones = 0;
    for (int i = 0; i < nBits; i++) ones += int'(p[i]);
    return ones;
  endfunction

  // Parity bit a correct transmitter sends: odd mode makes the total ones odd.
  function automatic logic sentParity(input logic [8:0] p, input int nBits, input int mode);
    if (mode == PAR_ODD) return (countOnes(p, nBits) % 2 == 0);
    return (countOnes(p, nBits) % 2 == 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int lane, input logic [8:0] payload, input bit flipPar,
                               input bit stopLow, input int abortBit, output int startCycle);
    logic bits[$];
    int   nBits = laneBits(lane);
    bits.push_back(1'b0);
    for (int i = 0; i < nBits; i++) bits.push_back(payload[i]);
    if (lanePar(lane) != PAR_NONE) bits.push_back(sentParity(payload, nBits, lanePar(lane)) ^ flipPar);
    for (int i = 0; i < laneStop(lane); i++) bits.push_back(!stopLow);
    startCycle = cyc + 1;
    foreach (bits[k]) begin
      rxLine[lane] = bits[k];
      if (abortBit >= 0 && k == abortBit + 1) begin
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxLine[lane] = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic checkRx(input string tag, input int lane, input logic [8:0] payload,
                         input bit flipPar, input bit stopLow, input int startCycle,
                         input bit checkLat);
    rxItem_t    it;
    bit         got = 1'b0;
    int         nBits = laneBits(lane);
    int         mode = lanePar(lane);
    int         total;
    logic       expPe;
    int         expLat;
    logic [8:0] expData;
    case (lane)
      0: if (qA.size() > 0) begin it = qA.pop_front(); got = 1'b1; end
      1: if (qB.size() > 0) begin it = qB.pop_front(); got = 1'b1; end
      default: if (qC.size() > 0) begin it = qC.pop_front(); got = 1'b1; end
    endcase
    checkOutput({tag, " frame delivered"}, got, 1);
    if (got) begin
      expData = payload & 9'((1 << nBits) - 1);
      total   = countOnes(payload, nBits) + int'(sentParity(payload, nBits, mode) ^ flipPar);
      expPe   = (mode == PAR_ODD)  ? (total % 2 == 0) :
                (mode == PAR_EVEN) ? (total % 2 == 1) : 1'b0;
      expLat  = 3 + HALF + (nBits + ((mode != PAR_NONE) ? 1 : 0) + laneStop(lane)) * CPB;
      checkOutput({tag, " data"}, it.data, expData);
      checkOutput({tag, " parity_err"}, it.pe, expPe);
      checkOutput({tag, " frame_err"}, it.fe, stopLow);
      if (checkLat) checkOutput({tag, " latency"}, it.cyc - startCycle, expLat);
    end
  endtask

  initial begin
    int         st0, st1, st2;
    int         busyBefore, qBefore;
    logic [8:0] p;
    bit         fp;
    rxItem_t    it;

    rst = 1'b1;
    rxLine = '1;
    repeat (3) @(negedge clk);
    checkOutput("reset data", ifA.data, 0);
    checkOutput("reset data_valid", ifA.data_valid, 0);
    checkOutput("reset parity_err", ifA.parity_err, 0);
    checkOutput("reset frame_err", ifA.frame_err, 0);
    checkOutput("reset busy A", ifA.busy, 0);
    checkOutput("reset busy B", ifB.busy, 0);
    checkOutput("reset data C", ifC.data, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    applyStimulus(0, 9'h0A5, 1'b0, 1'b0, -1, st0);
    checkRx("8N1 0xA5", 0, 9'h0A5, 1'b0, 1'b0, st0, 1'b1);

    applyStimulus(1, 9'h03C, 1'b0, 1'b0, -1, st0);
    checkRx("8E2 0x3C good parity", 1, 9'h03C, 1'b0, 1'b0, st0, 1'b1);
    applyStimulus(1, 9'h03C, 1'b1, 1'b0, -1, st0);
    checkRx("8E2 0x3C bad parity", 1, 9'h03C, 1'b1, 1'b0, st0, 1'b1);

    applyStimulus(0, 9'h055, 1'b0, 1'b1, -1, st0);
    rxLine[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkRx("8N1 0x55 stop low", 0, 9'h055, 1'b0, 1'b1, st0, 1'b1);
    checkOutput("no extra frame after framing error", qA.size(), 0);
    applyStimulus(0, 9'h012, 1'b0, 1'b0, -1, st0);
    checkRx("8N1 0x12 after framing error", 0, 9'h012, 1'b0, 1'b0, st0, 1'b1);

    busyBefore = busyCycA;
    qBefore = qA.size();
    rxLine[0] = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rxLine[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch busy pulsed", busyCycA > busyBefore, 1);
    checkOutput("glitch busy back to idle", ifA.busy, 0);
    checkOutput("glitch no frame", qA.size(), qBefore);

    applyStimulus(0, 9'h000, 1'b0, 1'b0, -1, st0);
    applyStimulus(0, 9'h0FF, 1'b0, 1'b0, -1, st1);
    applyStimulus(0, 9'h081, 1'b0, 1'b0, -1, st2);
    repeat (2 * CPB) @(negedge clk);
    checkRx("b2b 0x00", 0, 9'h000, 1'b0, 1'b0, st0, 1'b1);
    checkRx("b2b 0xFF", 0, 9'h0FF, 1'b0, 1'b0, st1, 1'b1);
    checkRx("b2b 0x81", 0, 9'h081, 1'b0, 1'b0, st2, 1'b1);

    qBefore = qA.size();
    applyStimulus(0, 9'h0C3, 1'b0, 1'b0, 4, st0);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("reset mid-frame no frame", qA.size(), qBefore);
    checkOutput("reset mid-frame idle", ifA.busy, 0);
    p = 9'($urandom_range(0, 255));
    applyStimulus(0, p, 1'b0, 1'b0, -1, st0);
    checkRx("frame after reset", 0, p, 1'b0, 1'b0, st0, 1'b1);

    applyStimulus(2, 9'h041, 1'b0, 1'b0, -1, st0);
    checkRx("7O1 0x41", 2, 9'h041, 1'b0, 1'b0, st0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int lane = 0; lane < 3; lane++) begin
        p  = 9'($urandom_range(0, (1 << laneBits(lane)) - 1));
        fp = (lanePar(lane) != PAR_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
        applyStimulus(lane, p, fp, 1'b0, -1, st0);
        checkRx($sformatf("random lane%0d round%0d", lane, r), lane, p, fp, 1'b0, st0, 1'b1);
      end
    end

    rxLine[0] = 1'b0;
    repeat (420) @(negedge clk);
    rxLine[0] = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("break repeated frames", qA.size() >= 2, 1);
    for (int i = 0; i < 2; i++) begin
      if (qA.size() > 0) begin
        it = qA.pop_front();
        checkOutput($sformatf("break frame%0d data", i), it.data, 0);
        checkOutput($sformatf("break frame%0d frame_err", i), it.fe, 1);
        checkOutput($sformatf("break frame%0d parity_err", i), it.pe, 0);
      end
    end
    qA.delete();
    checkOutput("break recovered to idle", ifA.busy, 0);

    checkOutput("error flags only with data_valid", flagViol, 0);
    checkOutput("no stray frames lane B", qB.size(), 0);
    checkOutput("no stray frames lane C", qC.size(), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
